// File: rtl/vga_pkg.sv
// Shared VGA timing constants and line-fetch FSM encoding, used by the
// timing generator and the framebuffer fetch controller.
package vga_pkg;

    localparam int VGA_H_ACT = 800;
    localparam int VGA_V_ACT = 600;
    localparam int VGA_BURST = 16;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        ARMED      = 2'd1,
        WAIT_SPACE = 2'd2,
        FETCH      = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/vga_addr_gen.sv
// Burst start address: base + line*H_ACT + burst*BURST (mod 2^AW), registered.
// Counters settle while the FSM sits in WAIT_SPACE, so the result is ready when mem_req rises.
module vga_addr_gen
    import vga_pkg::*;
#(
    parameter int H_ACT = VGA_H_ACT,
    parameter int BURST = VGA_BURST,
    parameter int AW    = 24,
    parameter int LW    = 10,
    parameter int BW    = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] base_i,
    input  logic [LW-1:0] line_i,
    input  logic [BW-1:0] burst_i,
    output logic [AW-1:0] addr_o
);

    logic [AW-1:0] addr_q;
    logic [AW-1:0] addr_d;

    always_comb begin
        addr_d = base_i + (AW'(line_i) * AW'(H_ACT)) + (AW'(burst_i) * AW'(BURST));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_q <= '0;
        end else begin
            addr_q <= addr_d;
        end
    end

    assign addr_o = addr_q;

endmodule

// File: rtl/vga_line_fetch_ctrl.sv
// Framebuffer line fetch controller: issues BURST-word read requests for each
// displayed line, gated by downstream FIFO space, with sticky underrun detection.
module vga_line_fetch_ctrl
    import vga_pkg::*;
#(
    parameter int H_ACT = VGA_H_ACT,
    parameter int V_ACT = VGA_V_ACT,
    parameter int BURST = VGA_BURST,
    parameter int AW    = 24
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          enable,
    input  logic [AW-1:0] base_addr,
    input  logic          frame_start,
    input  logic          line_start,
    input  logic          next_line_active,
    input  logic [10:0]   fifo_space,
    output logic          mem_req,
    output logic [AW-1:0] mem_addr,
    input  logic          mem_ack,
    output logic [9:0]    line_idx,
    output logic          busy,
    output logic          underrun,
    input  logic          underrun_clr
);

    localparam int NBURST = H_ACT / BURST;
    localparam int BW     = (NBURST > 1) ? $clog2(NBURST) : 1;
    localparam logic [BW-1:0] LAST_BURST = BW'(NBURST - 1);
    localparam logic [9:0]    LINE_END   = 10'(V_ACT);

    fetch_state_e  state_q, state_d;
    logic [9:0]    line_q, line_d;
    logic [BW-1:0] bcnt_q, bcnt_d;
    logic [AW-1:0] shadow_base_q, shadow_base_d;
    logic          shadow_en_q, shadow_en_d;
    logic          underrun_q, underrun_d;
    logic          mem_req_q;
    logic          accept;
    logic [9:0]    line_inc;

    assign accept   = mem_req_q && mem_ack;
    assign line_inc = line_q + 10'd1;

    always_comb begin
        state_d       = state_q;
        line_d        = line_q;
        bcnt_d        = bcnt_q;
        shadow_base_d = shadow_base_q;
        shadow_en_d   = shadow_en_q;
        underrun_d    = underrun_q && !underrun_clr;

        // frame_start overrides every other event in the same cycle
        if (frame_start) begin
            shadow_base_d = base_addr;
            shadow_en_d   = enable;
            line_d        = '0;
            bcnt_d        = '0;
            if (!enable) begin
                state_d = IDLE;
            end else if (line_start && next_line_active) begin
                state_d = WAIT_SPACE;
            end else begin
                state_d = ARMED;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = IDLE;
                end
                ARMED: begin
                    if (line_start && next_line_active && shadow_en_q) begin
                        state_d = WAIT_SPACE;
                    end
                end
                WAIT_SPACE, FETCH: begin
                    if (line_start) begin
                        // Line time ran out: drop the rest of this line, move on
                        underrun_d = 1'b1;
                        line_d     = line_inc;
                        bcnt_d     = '0;
                        if (line_inc == LINE_END) begin
                            state_d = IDLE;
                        end else if (next_line_active) begin
                            state_d = WAIT_SPACE;
                        end else begin
                            state_d = ARMED;
                        end
                    end else if (state_q == WAIT_SPACE) begin
                        if (fifo_space >= 11'(BURST)) begin
                            state_d = FETCH;
                        end
                    end else if (accept) begin
                        if (bcnt_q == LAST_BURST) begin
                            bcnt_d  = '0;
                            line_d  = line_inc;
                            state_d = (line_inc == LINE_END) ? IDLE : ARMED;
                        end else begin
                            bcnt_d  = bcnt_q + 1'b1;
                            state_d = WAIT_SPACE;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            line_q        <= '0;
            bcnt_q        <= '0;
            shadow_base_q <= '0;
            shadow_en_q   <= 1'b0;
            underrun_q    <= 1'b0;
            mem_req_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            line_q        <= line_d;
            bcnt_q        <= bcnt_d;
            shadow_base_q <= shadow_base_d;
            shadow_en_q   <= shadow_en_d;
            underrun_q    <= underrun_d;
            mem_req_q     <= (state_d == FETCH);
        end
    end

    vga_addr_gen #(
        .H_ACT (H_ACT),
        .BURST (BURST),
        .AW    (AW),
        .LW    (10),
        .BW    (BW)
    ) u_addr_gen (
        .clk     (clk),
        .rst_n   (rst_n),
        .base_i  (shadow_base_q),
        .line_i  (line_q),
        .burst_i (bcnt_q),
        .addr_o  (mem_addr)
    );

    assign mem_req  = mem_req_q;
    assign line_idx = line_q;
    assign busy     = (state_q == WAIT_SPACE) || (state_q == FETCH);
    assign underrun = underrun_q;

endmodule

// File: tb/tb_vga_line_fetch_ctrl.sv
// Directed bench for vga_line_fetch_ctrl: per-cycle vector table plus
// hand-written multi-cycle sequences (line fetch, FIFO stall, underrun, reset, full frame).
module tb_vga_line_fetch_ctrl;

    localparam int AW = 24;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          enable;
    logic [AW-1:0] base_addr;
    logic          frame_start;
    logic          line_start;
    logic          next_line_active;
    logic [10:0]   fifo_space;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic          mem_ack;
    logic [9:0]    line_idx;
    logic          busy;
    logic          underrun;
    logic          underrun_clr;

    vga_line_fetch_ctrl #(
        .H_ACT (800),
        .V_ACT (600),
        .BURST (16),
        .AW    (AW)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .enable           (enable),
        .base_addr        (base_addr),
        .frame_start      (frame_start),
        .line_start       (line_start),
        .next_line_active (next_line_active),
        .fifo_space       (fifo_space),
        .mem_req          (mem_req),
        .mem_addr         (mem_addr),
        .mem_ack          (mem_ack),
        .line_idx         (line_idx),
        .busy             (busy),
        .underrun         (underrun),
        .underrun_clr     (underrun_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        fs;
        logic        en;
        logic        ls;
        logic        nla;
        logic        ack;
        logic        clr;
        logic [10:0] fifo;
        logic [23:0] base;
        logic        req;
        logic        bsy;
        logic        und;
        logic [9:0]  line;
        logic [23:0] addr;
    } vec_t;

    vec_t tbl [16];

    int n_chk  = 0;
    int n_pass = 0;

    // Accepted-burst monitor with an independent address model
    int acc_cnt   = 0;
    int addr_err  = 0;
    int acc_start = 0;
    int mon_base  = 0;
    logic mon_on  = 1'b0;
    int mk;
    int mea;

    always @(negedge clk) begin
        if (mon_on && mem_req && mem_ack) begin
            mk  = acc_cnt - acc_start;
            mea = mon_base + (mk / 50) * 800 + (mk % 50) * 16;
            if (mem_addr !== mea[23:0]) addr_err++;
            acc_cnt++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic ack_bursts(input int n, input int bound);
        int given = 0;
        int cyc   = 0;
        while (given < n && cyc < bound) begin
            step();
            cyc++;
            if (mem_req && !mem_ack) begin
                mem_ack = 1'b1;
                given++;
            end else begin
                mem_ack = 1'b0;
            end
        end
        step();
        mem_ack = 1'b0;
        check("ack_bursts_done", 32'(given), 32'(n));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req"},  32'(mem_req),  32'd0);
        check({tag, "_addr"}, 32'(mem_addr), 32'd0);
        check({tag, "_line"}, 32'(line_idx), 32'd0);
        check({tag, "_busy"}, 32'(busy),     32'd0);
        check({tag, "_und"},  32'(underrun), 32'd0);
    endtask

    initial begin
        int err_start;
        int seen;

        rst_n            = 1'b0;
        enable           = 1'b0;
        base_addr        = '0;
        frame_start      = 1'b0;
        line_start       = 1'b0;
        next_line_active = 1'b0;
        fifo_space       = 11'd2047;
        mem_ack          = 1'b0;
        underrun_clr     = 1'b0;

        repeat (3) step();
        check_reset_outputs("reset");
        rst_n = 1'b1;
        step();

        //            fs    en    ls    nla   ack   clr   fifo      base       | req  bsy   und   line   addr
        tbl[0]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 11'd2047, 24'h000100, 1'b0, 1'b1, 1'b0, 10'd0, 24'h000000};
        tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 11'd2047, 24'h000100, 1'b1, 1'b1, 1'b0, 10'd0, 24'h000100};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 11'd2047, 24'h000100, 1'b0, 1'b1, 1'b0, 10'd0, 24'h000100};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 11'd15,   24'h000100, 1'b0, 1'b1, 1'b0, 10'd0, 24'h000110};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 11'd16,   24'h000100, 1'b1, 1'b1, 1'b0, 10'd0, 24'h000110};
        tbl[5]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 11'd16,   24'h000100, 1'b0, 1'b1, 1'b1, 10'd1, 24'h000110};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 11'd2047, 24'h000100, 1'b1, 1'b1, 1'b0, 10'd1, 24'h000420};
        tbl[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 11'd2047, 24'h000100, 1'b0, 1'b0, 1'b1, 10'd2, 24'h000420};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 11'd2047, 24'h000100, 1'b0, 1'b0, 1'b1, 10'd2, 24'h000740};
        tbl[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 11'd2047, 24'h000100, 1'b0, 1'b0, 1'b1, 10'd2, 24'h000740};
        tbl[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 11'd2047, 24'h000200, 1'b0, 1'b0, 1'b0, 10'd0, 24'h000740};
        tbl[11] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 11'd2047, 24'h000200, 1'b0, 1'b1, 1'b0, 10'd0, 24'h000200};
        tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 11'd2047, 24'h000200, 1'b1, 1'b1, 1'b0, 10'd0, 24'h000200};
        tbl[13] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 11'd2047, 24'h000200, 1'b0, 1'b0, 1'b0, 10'd0, 24'h000200};
        tbl[14] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 11'd2047, 24'h000200, 1'b0, 1'b0, 1'b0, 10'd0, 24'h000200};
        tbl[15] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 11'd2047, 24'h000200, 1'b0, 1'b0, 1'b0, 10'd0, 24'h000200};

        for (int i = 0; i < 16; i++) begin
            frame_start      = tbl[i].fs;
            enable           = tbl[i].en;
            line_start       = tbl[i].ls;
            next_line_active = tbl[i].nla;
            mem_ack          = tbl[i].ack;
            underrun_clr     = tbl[i].clr;
            fifo_space       = tbl[i].fifo;
            base_addr        = tbl[i].base;
            step();
            check($sformatf("row%0d_req", i),  32'(mem_req),  32'(tbl[i].req));
            check($sformatf("row%0d_busy", i), 32'(busy),     32'(tbl[i].bsy));
            check($sformatf("row%0d_und", i),  32'(underrun), 32'(tbl[i].und));
            check($sformatf("row%0d_line", i), 32'(line_idx), 32'(tbl[i].line));
            check($sformatf("row%0d_addr", i), 32'(mem_addr), 32'(tbl[i].addr));
        end
        frame_start = 1'b0; line_start = 1'b0; next_line_active = 1'b0;
        mem_ack = 1'b0; underrun_clr = 1'b0; fifo_space = 11'd2047;

        // Line 0 fetch, base 0x100, ack one cycle after each request
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        base_addr = 24'h000100;
        enable = 1'b1;
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        acc_start = acc_cnt;
        err_start = addr_err;
        mon_base = 32'h100;
        mon_on = 1'b1;
        line_start = 1'b1; next_line_active = 1'b1;
        step();
        line_start = 1'b0;
        ack_bursts(50, 400);
        check("s1_bursts", 32'(acc_cnt - acc_start), 32'd50);
        check("s1_addr_errs", 32'(addr_err - err_start), 32'd0);
        check("s1_line", 32'(line_idx), 32'd1);
        check("s1_busy", 32'(busy), 32'd0);

        // FIFO space held below one burst
        fifo_space = 11'd15;
        line_start = 1'b1;
        step();
        line_start = 1'b0;
        seen = 0;
        for (int c = 0; c < 20; c++) begin
            step();
            if (mem_req) seen++;
        end
        check("s2_req_while_full", 32'(seen), 32'd0);
        fifo_space = 11'd16;
        step();
        check("s2_req_rise", 32'(mem_req), 32'd1);
        check("s2_line1_addr", 32'(mem_addr), 32'h420);

        // 30 bursts then stall on ack until the next line_start
        fifo_space = 11'd2047;
        ack_bursts(30, 300);
        step();
        check("s3_req_b30", 32'(mem_req), 32'd1);
        check("s3_addr_b30", 32'(mem_addr), 32'h600);
        check("s3_bursts", 32'(acc_cnt - acc_start), 32'd80);
        check("s3_addr_errs", 32'(addr_err - err_start), 32'd0);
        mon_on = 1'b0;
        repeat (3) step();
        check("s3_req_held", 32'(mem_req), 32'd1);
        line_start = 1'b1; next_line_active = 1'b1; mem_ack = 1'b1;
        step();
        line_start = 1'b0; mem_ack = 1'b0;
        check("s3_underrun", 32'(underrun), 32'd1);
        check("s3_line", 32'(line_idx), 32'd2);
        check("s3_req_drop", 32'(mem_req), 32'd0);
        check("s3_busy", 32'(busy), 32'd1);
        step();
        check("s3_req_new_line", 32'(mem_req), 32'd1);
        check("s3_addr_new_line", 32'(mem_addr), 32'h740);

        // Reset while a request is outstanding, with an ack in the same cycle
        rst_n = 1'b0;
        mem_ack = 1'b1;
        step();
        check_reset_outputs("s6");
        rst_n = 1'b1;
        mem_ack = 1'b0;
        line_start = 1'b1; next_line_active = 1'b1;
        step();
        line_start = 1'b0;
        check("s6_idle_after_reset", 32'(busy), 32'd0);

        // Full frame with ack held high
        base_addr = 24'h000100;
        enable = 1'b1;
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        mem_ack = 1'b1;
        acc_start = acc_cnt;
        err_start = addr_err;
        mon_base = 32'h100;
        mon_on = 1'b1;
        for (int ln = 0; ln < 600; ln++) begin
            line_start = 1'b1; next_line_active = 1'b1;
            step();
            line_start = 1'b0;
            repeat (103) step();
        end
        check("s5_bursts", 32'(acc_cnt - acc_start), 32'd30000);
        check("s5_addr_errs", 32'(addr_err - err_start), 32'd0);
        check("s5_line_end", 32'(line_idx), 32'd600);
        check("s5_idle_busy", 32'(busy), 32'd0);
        check("s5_idle_req", 32'(mem_req), 32'd0);
        check("s5_no_underrun", 32'(underrun), 32'd0);

        // Disabled frame: no requests at all
        mon_on = 1'b0;
        enable = 1'b0;
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        check("s5_dis_line_clear", 32'(line_idx), 32'd0);
        seen = 0;
        for (int ln = 0; ln < 2; ln++) begin
            line_start = 1'b1; next_line_active = 1'b1;
            step();
            line_start = 1'b0;
            for (int c = 0; c < 103; c++) begin
                step();
                if (mem_req || busy) seen++;
            end
        end
        check("s5_dis_no_req", 32'(seen), 32'd0);
        mem_ack = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
